// File: rtl/mem_stage_dcache.sv
// Memory-access stage: direct-mapped write-through data cache with a
// req/ack backing-memory port and a pipeline stall (hit) indication.
module mem_stage_dcache #(
  parameter int unsigned IDX_W = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [2:0]  ctlmem,
  input  logic        alu_zero,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        hit,
  output logic        pcsrc,
  output logic [31:0] rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned LINES = 1 << IDX_W;
  localparam int unsigned TAG_W = 32 - IDX_W - 2;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FILL  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic             mem_req_q, mem_req_d;
  logic             mem_we_q, mem_we_d;
  logic [31:0]      mem_addr_q, mem_addr_d;
  logic [31:0]      mem_wdata_q, mem_wdata_d;
  logic [31:0]      ld_data_q, ld_data_d;
  logic [LINES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0] tag_q [LINES];
  logic [TAG_W-1:0] tag_d [LINES];
  logic [31:0]      data_q [LINES];
  logic [31:0]      data_d [LINES];

  logic             is_store;
  logic             is_load;
  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;
  logic [IDX_W-1:0] acc_idx;
  logic [TAG_W-1:0] acc_tag;
  logic             lookup_hit;
  logic             line_match;
  logic             addr_unused;

  // Store wins over load when both controls are set.
  assign is_store   = ctlmem[0];
  assign is_load    = ctlmem[1] & ~ctlmem[0];
  assign req_idx    = addr[IDX_W+1:2];
  assign req_tag    = addr[31:IDX_W+2];
  // Outstanding accesses index the cache from the latched request address.
  assign acc_idx    = mem_addr_q[IDX_W+1:2];
  assign acc_tag    = mem_addr_q[31:IDX_W+2];
  assign lookup_hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign line_match = valid_q[acc_idx] && (tag_q[acc_idx] == acc_tag);
  // Byte-offset bits carry no information for a word-granular cache.
  assign addr_unused = ^addr[1:0];

  assign pcsrc     = ctlmem[2] & alu_zero;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  // Next-state, cache update and combinational hit/rdata decode.
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    ld_data_d   = ld_data_q;
    valid_d     = valid_q;
    tag_d       = tag_q;
    data_d      = data_q;
    hit         = 1'b0;
    rdata       = data_q[req_idx];

    case (state_q)
      S_IDLE: begin
        if (is_store) begin
          mem_addr_d  = {addr[31:2], 2'b00};
          mem_wdata_d = wdata;
          mem_we_d    = 1'b1;
          mem_req_d   = 1'b1;
          state_d     = S_WRITE;
        end else if (is_load && !lookup_hit) begin
          mem_addr_d  = {addr[31:2], 2'b00};
          mem_we_d    = 1'b0;
          mem_req_d   = 1'b1;
          state_d     = S_FILL;
        end else begin
          hit = 1'b1;
        end
      end
      S_FILL: begin
        if (mem_ack) begin
          valid_d[acc_idx] = 1'b1;
          tag_d[acc_idx]   = acc_tag;
          data_d[acc_idx]  = mem_rdata;
          ld_data_d        = mem_rdata;
          mem_req_d        = 1'b0;
          state_d          = S_DONE;
        end
      end
      S_WRITE: begin
        if (mem_ack) begin
          // Write-update only; a store miss never allocates.
          if (line_match) begin
            data_d[acc_idx] = mem_wdata_q;
          end
          mem_req_d = 1'b0;
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        hit     = 1'b1;
        rdata   = ld_data_q;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, request and cache registers; reset aborts any outstanding access.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      ld_data_q   <= '0;
      valid_q     <= '0;
      for (int i = 0; i < int'(LINES); i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      ld_data_q   <= ld_data_d;
      valid_q     <= valid_d;
      tag_q       <= tag_d;
      data_q      <= data_d;
    end
  end

endmodule
